// File: rtl/dram_port_responder_if.sv
// Bundle of the four core request ports plus the DRAM macro pins.
// The responder takes the slave side; cores/RAM (or a bench) take the master side.
interface dram_port_responder_if #(
  parameter int N_PORTS = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8
);
  // Handshake: a core holds i_rd/i_wr with stable i_addr/i_wdata until it
  // sees its one-cycle o_ack bit; a request still high after that is a new one.
  logic [N_PORTS-1:0]        i_rd;
  logic [N_PORTS-1:0]        i_wr;
  logic [N_PORTS*ADDR_W-1:0] i_addr;
  logic [N_PORTS*DATA_W-1:0] i_wdata;
  logic [N_PORTS*DATA_W-1:0] o_rdata;
  logic [N_PORTS-1:0]        o_ack;
  logic                      o_busy;
  logic [$clog2(N_PORTS)-1:0] o_grant;
  logic [ADDR_W-1:0]         o_mem_addr;
  logic [DATA_W-1:0]         o_mem_wdata;
  logic                      o_mem_we;
  logic                      o_mem_re;
  logic [DATA_W-1:0]         i_mem_rdata;
  logic [1:0]                dbg_state;

  modport slave (
    input  i_rd, i_wr, i_addr, i_wdata, i_mem_rdata,
    output o_rdata, o_ack, o_busy, o_grant,
    output o_mem_addr, o_mem_wdata, o_mem_we, o_mem_re, dbg_state
  );

  modport master (
    output i_rd, i_wr, i_addr, i_wdata, i_mem_rdata,
    input  o_rdata, o_ack, o_busy, o_grant,
    input  o_mem_addr, o_mem_wdata, o_mem_we, o_mem_re, dbg_state
  );
endinterface

// File: rtl/dram_port_responder.sv
// Round-robin responder sharing one single-port synchronous RAM (1-cycle read
// latency) between four core request ports; acks the granted core for one cycle.
module dram_port_responder #(
  parameter int N_PORTS = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  dram_port_responder_if.slave  bus
);
  localparam int GW = $clog2(N_PORTS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_e;

  state_e                     state_q, state_d;
  logic [GW-1:0]              ptr_q, ptr_d;
  logic [GW-1:0]              grant_q, grant_d;
  logic                       is_wr_q, is_wr_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic [DATA_W-1:0]          wdata_q, wdata_d;
  logic [N_PORTS*DATA_W-1:0]  rdata_q, rdata_d;

  logic [N_PORTS-1:0]         req;
  logic [GW-1:0]              pick;
  logic [GW-1:0]              idx;
  logic                       found;

  assign req = bus.i_rd | bus.i_wr;

  // Search order ptr, ptr+1, ... relies on N_PORTS being a power of two so the
  // index wraps by truncation.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    idx   = ptr_q;
    for (int i = 0; i < N_PORTS; i++) begin
      idx = ptr_q + GW'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (found) state_d = ISSUE;
      ISSUE:   state_d = is_wr_q ? ACK : WAIT;
      WAIT:    state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A write wins when rd and wr are both set; the read path is never started.
  always_comb begin
    ptr_d   = ptr_q;
    grant_d = grant_q;
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (state_q == IDLE && found) begin
      grant_d = pick;
      is_wr_d = bus.i_wr[pick];
      addr_d  = bus.i_addr[pick*ADDR_W +: ADDR_W];
      wdata_d = bus.i_wdata[pick*DATA_W +: DATA_W];
    end
    if (state_q == WAIT) begin
      rdata_d[grant_q*DATA_W +: DATA_W] = bus.i_mem_rdata;
    end
    if (state_q == ACK) begin
      ptr_d = grant_q + GW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q   <= '0;
      grant_q <= '0;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    bus.o_ack    = '0;
    bus.o_mem_we = 1'b0;
    bus.o_mem_re = 1'b0;
    if (state_q == ISSUE) begin
      bus.o_mem_we = is_wr_q;
      bus.o_mem_re = !is_wr_q;
    end
    if (state_q == ACK) begin
      bus.o_ack[grant_q] = 1'b1;
    end
  end

  // Address/data registers load at grant, so the RAM pins hold outside ISSUE.
  assign bus.o_mem_addr  = addr_q;
  assign bus.o_mem_wdata = wdata_q;
  assign bus.o_rdata     = rdata_q;
  assign bus.o_grant     = grant_q;
  assign bus.o_busy      = (state_q != IDLE);
  assign bus.dbg_state   = state_q;

  a_we_re_excl: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(bus.o_mem_we && bus.o_mem_re));
  a_ack_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    $onehot0(bus.o_ack));
endmodule

// File: tb/tb_dram_port_responder.sv
// Bench for dram_port_responder: directed scenarios then randomized traffic,
// checked against a transaction-level model (RR pick, memory map, per-lane read data).
module tb_dram_port_responder;
  localparam int N = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0, checks = 0, errors = 0, last_ack = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dram_port_responder_if bus ();
  dram_port_responder dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus.slave));

  // RAM stand-in: synchronous read, q valid the cycle after the read enable.
  logic [7:0]  ram [0:65535];
  logic        pre_we   = 1'b0;
  logic [15:0] pre_addr = '0;
  logic [7:0]  pre_data = '0;
  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (bus.o_mem_we) ram[bus.o_mem_addr] <= bus.o_mem_wdata;
    if (bus.o_mem_re) bus.i_mem_rdata <= ram[bus.o_mem_addr];
  end

  // Reference model state.
  logic [7:0]  ref_mem [logic [15:0]];
  logic [31:0] ref_rdata = '0;
  int          ref_ptr = 0;

  // Requests currently presented by each core.
  logic        rq_rd    [N];
  logic        rq_wr    [N];
  logic [15:0] rq_addr  [N];
  logic [7:0]  rq_wdata [N];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int p = 0; p < N; p++) begin
      bus.i_rd[p] = rq_rd[p];
      bus.i_wr[p] = rq_wr[p];
      bus.i_addr[p*16 +: 16] = rq_addr[p];
      bus.i_wdata[p*8 +: 8]  = rq_wdata[p];
    end
  endtask

  task automatic set_req(input int p, input logic rd, input logic wr,
                         input logic [15:0] a, input logic [7:0] d);
    rq_rd[p] = rd; rq_wr[p] = wr; rq_addr[p] = a; rq_wdata[p] = d;
    drive();
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    tick();
    pre_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ack"},   32'(bus.o_ack), 32'd0);
    chk({tag, "_rdata"}, bus.o_rdata, 32'd0);
    chk({tag, "_busy"},  32'(bus.o_busy), 32'd0);
    chk({tag, "_grant"}, 32'(bus.o_grant), 32'd0);
    chk({tag, "_we_re"}, 32'({bus.o_mem_we, bus.o_mem_re}), 32'd0);
    chk({tag, "_maddr"}, 32'(bus.o_mem_addr), 32'd0);
    chk({tag, "_mwdat"}, 32'(bus.o_mem_wdata), 32'd0);
  endtask

  task automatic do_reset();
    for (int p = 0; p < N; p++) begin
      rq_rd[p] = 1'b0; rq_wr[p] = 1'b0; rq_addr[p] = '0; rq_wdata[p] = '0;
    end
    drive();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    ref_ptr = 0;
    ref_rdata = '0;
  endtask

  function automatic int model_pick();
    int p;
    for (int i = 0; i < N; i++) begin
      p = (ref_ptr + i) % N;
      if (rq_rd[p] || rq_wr[p]) return p;
    end
    return -1;
  endfunction

  // Serve the transaction the model predicts next and check it end to end.
  task automatic run_one(input bit first, input int t0, input logic [3:0] keep,
                         output int served);
    int exp_p, got_p, nwe, nre, nboth;
    bit wr;
    logic [15:0] a;
    logic [7:0]  d;
    served = -1;
    exp_p = model_pick();
    if (exp_p < 0) return;
    wr = rq_wr[exp_p];
    a  = rq_addr[exp_p];
    d  = rq_wdata[exp_p];
    got_p = -1; nwe = 0; nre = 0; nboth = 0;
    for (int k = 0; k < 20 && got_p < 0; k++) begin
      tick();
      if (bus.o_mem_we) nwe++;
      if (bus.o_mem_re) nre++;
      if (bus.o_mem_we && bus.o_mem_re) nboth++;
      for (int q = N - 1; q >= 0; q--) if (bus.o_ack[q]) got_p = q;
    end
    chk("ack_seen", 32'(got_p >= 0), 32'd1);
    if (got_p < 0) return;
    served = got_p;
    chk("ack_vec", 32'(bus.o_ack), 32'd1 << exp_p);
    chk("grant",   32'(bus.o_grant), 32'(exp_p));
    chk("busy",    32'(bus.o_busy), 32'd1);
    if (first) chk("latency", 32'(cyc - t0), wr ? 32'd2 : 32'd3);
    else       chk("ack_gap", 32'(cyc - last_ack), wr ? 32'd3 : 32'd4);
    last_ack = cyc;
    chk("we_cnt",  32'(nwe), 32'(wr));
    chk("re_cnt",  32'(nre), 32'(!wr));
    chk("we_re_both", 32'(nboth), 32'd0);
    if (wr) begin
      ref_mem[a] = d;
      chk("ram_write", 32'(ram[a]), 32'(d));
    end else begin
      ref_rdata[exp_p*8 +: 8] = ref_mem[a];
    end
    chk("rdata", bus.o_rdata, ref_rdata);
    ref_ptr = (exp_p + 1) % N;
    if (!keep[exp_p]) begin
      rq_rd[exp_p] = 1'b0;
      rq_wr[exp_p] = 1'b0;
      drive();
    end
    tick();
    chk("ack_pulse", 32'(bus.o_ack), 32'd0);
  endtask

  initial begin
    int s, t0, n0, nack;
    bit s3, any;
    logic [15:0] pool [8];

    for (int p = 0; p < N; p++) begin
      rq_rd[p] = 1'b0; rq_wr[p] = 1'b0; rq_addr[p] = '0; rq_wdata[p] = '0;
    end
    drive();
    #2;
    chk_zero_outputs("rst");
    do_reset();

    // Port 2 read of a preloaded word.
    preload(16'h0123, 8'hA5);
    set_req(2, 1'b1, 1'b0, 16'h0123, 8'h00);
    t0 = cyc;
    run_one(1'b1, t0, 4'b0000, s);
    chk("t1_port", 32'(s), 32'd2);

    // Port 1 write then read back.
    set_req(1, 1'b0, 1'b1, 16'h0040, 8'h3C);
    t0 = cyc;
    run_one(1'b1, t0, 4'b0000, s);
    set_req(1, 1'b1, 1'b0, 16'h0040, 8'h00);
    t0 = cyc;
    run_one(1'b1, t0, 4'b0000, s);
    chk("t2_rd_lane1", 32'(bus.o_rdata[15:8]), 32'h3C);

    // All four read from reset: served 0,1,2,3 back to back.
    do_reset();
    for (int p = 0; p < N; p++) preload(16'h1000 + 16'(p), 8'($urandom));
    for (int p = 0; p < N; p++) set_req(p, 1'b1, 1'b0, 16'h1000 + 16'(p), 8'h00);
    t0 = cyc;
    for (int p = 0; p < N; p++) begin
      run_one(p == 0, t0, 4'b0000, s);
      chk("t3_order", 32'(s), 32'(p));
    end
    // Pointer wrapped to 0: with ports 1 and 3 pending, 1 goes first.
    set_req(3, 1'b1, 1'b0, 16'h1003, 8'h00);
    set_req(1, 1'b1, 1'b0, 16'h1001, 8'h00);
    t0 = cyc;
    run_one(1'b1, t0, 4'b0000, s);
    chk("t3_wrap_first", 32'(s), 32'd1);
    run_one(1'b0, t0, 4'b0000, s);
    chk("t3_wrap_second", 32'(s), 32'd3);

    // Port 0 hogs, port 3 asks once.
    set_req(0, 1'b1, 1'b0, 16'h0123, 8'h00);
    set_req(3, 1'b0, 1'b1, 16'h0500, 8'h5A);
    t0 = cyc; n0 = 0; s3 = 1'b0;
    for (int t = 0; t < 4 && !s3; t++) begin
      run_one(t == 0, t0, 4'b0001, s);
      if (s == 0) n0++;
      if (s == 3) s3 = 1'b1;
    end
    chk("t4_p3_served", 32'(s3), 32'd1);
    chk("t4_p0_not_twice", 32'(n0 <= 1), 32'd1);
    run_one(1'b0, t0, 4'b0000, s);
    chk("t4_drain", 32'(s), 32'd0);

    // rd and wr together is a write.
    set_req(0, 1'b1, 1'b1, 16'h0200, 8'h77);
    t0 = cyc;
    run_one(1'b1, t0, 4'b0000, s);
    chk("t5_ram", 32'(ram[16'h0200]), 32'h77);

    // Reset during WAIT drops the read; the held request is re-served afterwards.
    set_req(1, 1'b1, 1'b0, 16'h0040, 8'h00);
    tick();
    tick();
    chk("t6_in_wait", 32'(bus.dbg_state), 32'd2);
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("t6");
    nack = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (|bus.o_ack) nack++;
    end
    chk("t6_no_ack", 32'(nack), 32'd0);
    rst_n = 1'b1;
    ref_ptr = 0;
    ref_rdata = '0;
    t0 = cyc;
    run_one(1'b1, t0, 4'b0000, s);
    chk("t6_reserved", 32'(s), 32'd1);

    // Randomized rounds of concurrent mixed requests.
    for (int i = 0; i < 8; i++) begin
      pool[i] = 16'h3000 + 16'(i * 17);
      preload(pool[i], 8'($urandom));
    end
    for (int r = 0; r < 30; r++) begin
      any = 1'b0;
      for (int p = 0; p < N; p++) begin
        if ($urandom_range(0, 1) == 1) begin
          case ($urandom_range(0, 2))
            0:       set_req(p, 1'b1, 1'b0, pool[$urandom_range(0, 7)], 8'($urandom));
            1:       set_req(p, 1'b0, 1'b1, pool[$urandom_range(0, 7)], 8'($urandom));
            default: set_req(p, 1'b1, 1'b1, pool[$urandom_range(0, 7)], 8'($urandom));
          endcase
          any = 1'b1;
        end
      end
      if (!any) set_req($urandom_range(0, 3), 1'b1, 1'b0, pool[$urandom_range(0, 7)], 8'h00);
      t0 = cyc;
      for (int t = 0; t < N && model_pick() >= 0; t++) begin
        run_one(t == 0, t0, 4'b0000, s);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dram_port_responder.md
Name: dram_port_responder

Overview:
- Shared-DRAM responder serving the four cores' DRAM request ports (16-bit address, 8-bit data).
- Arbitrates the ports round-robin and drives one single-port synchronous RAM with 1-cycle read latency.
- Returns read data and a one-cycle acknowledge to the granted core.
- Sits between the four core instances and the DRAM macro, on the divided system clock.

Parameters:
- N_PORTS, 4, number of requesting cores (fixed at 4; bench checks only 4)
- ADDR_W, 16, DRAM address width
- DATA_W, 8, DRAM data width

Ports:
- i_clk  input  1  system clock (divided clock), all logic on rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_rd  input  4  per-port read request, bit p = core p
- i_wr  input  4  per-port write request
- i_addr  input  64  per-port address, port p in bits [16p+15:16p]
- i_wdata  input  32  per-port write data, port p in bits [8p+7:8p]
- o_rdata  output  32  per-port read data, port p in bits [8p+7:8p]
- o_ack  output  4  one-cycle completion pulse, bit p = port p
- o_busy  output  1  high whenever state != IDLE
- o_grant  output  2  index of the port currently (or last) served
- o_mem_addr  output  16  RAM address
- o_mem_wdata  output  8  RAM write data
- o_mem_we  output  1  RAM write enable
- o_mem_re  output  1  RAM read enable
- i_mem_rdata  input  8  RAM q, valid 1 cycle after the o_mem_re edge

Behaviour:
- Reset (async, any time including mid-transaction):
  - o_ack=0, o_rdata=0, o_busy=0, o_grant=0, o_mem_we=0, o_mem_re=0, o_mem_addr=0, o_mem_wdata=0.
  - RR pointer=0, state=IDLE. An in-flight request is dropped and no ack is issued.
- Request handshake:
  - Core asserts i_rd[p] or i_wr[p] and holds address/data stable until it sees o_ack[p].
  - Request is level-sensitive. If it is still high in the cycle after the ack, it is a new request.
  - If both i_rd[p] and i_wr[p] are high, the request is a write; no read is performed.
- Arbitration in IDLE:
  - Search starts at the RR pointer and takes the first port with rd|wr set, in order ptr, ptr+1, ... mod 4.
  - Grant index, rd/wr type, address and wdata are registered. o_grant is updated.
  - Requests are not sampled again until the transaction completes.
- State machine (one transition per rising edge):
  - IDLE -> ISSUE on any request; otherwise stays in IDLE.
  - ISSUE: drive o_mem_addr/o_mem_wdata from the registered values. Assert o_mem_we (write) or o_mem_re (read) for exactly this one cycle. Read -> WAIT, write -> ACK.
  - WAIT: capture i_mem_rdata into o_rdata[grant] at the end of the cycle. -> ACK.
  - ACK: o_ack[grant]=1 for exactly one cycle. RR pointer <= grant+1 (2-bit wrap, 3 -> 0). -> IDLE.
- Latency, counted from the edge that samples the request in IDLE:
  - Read: o_ack high after edge +3 (4 cycles, request to ack).
  - Write: o_ack high after edge +2.
  - Back-to-back service of the next port: its ack comes 4 (read) or 3 (write) cycles after the previous ack.
- o_rdata[p]:
  - Changes only in WAIT for a read by port p; held otherwise, including across other ports' transactions and writes.
  - Valid no later than the o_ack[p] cycle.
- o_mem_addr/o_mem_wdata hold their last value outside ISSUE. o_mem_we and o_mem_re are never high together.
- Fairness: a continuously requesting port is served at least once every 4 transactions.
- Requests that drop before being granted are simply not served. There is no error flag.

Test Plan:
- Reset, RAM[0x0123]=0xA5; port 2 rd, addr 0x0123 -> o_mem_re one cycle, o_ack=4'b0100 after 3 edges, o_rdata[23:16]=0xA5, other lanes 0.
- Port 1 wr addr 0x0040 data 0x3C, then rd same addr -> write ack 2 edges after request, RAM[0x0040]=0x3C, read returns 0x3C on lane 1.
- All four ports rd from reset, held until acked -> acks in order 0,1,2,3, one every 4 cycles; o_grant follows; RR pointer ends at 0.
- Port 0 requests continuously, port 3 asserts once -> port 3 acked within 4 transactions; no port served twice before port 3.
- Port 0 with i_rd=i_wr=1, data 0x77 -> o_mem_we only, o_mem_re never high, RAM updated to 0x77, ack after 2 edges.
- Assert i_rst_n=0 during WAIT of a read -> all outputs 0 immediately, no ack; after release the same held request is re-served from IDLE with full latency.
